// File: rtl/branch_resolver.sv
// EX-stage branch resolution: mispredict detection, flush/redirect, RAS undo.
// Optional macro BRANCH_STAT_EN adds saturating branch statistics counters.
module branch_resolver #(
    parameter int PC_WIDTH = 32
`ifdef BRANCH_STAT_EN
    ,
    parameter int STAT_WIDTH = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PL_stall,
    input  logic                B_type_if,
    input  logic                B_type_prediction_result,
    input  logic                jalr_if,
    input  logic [PC_WIDTH-1:0] jalr_pc_prediction,
    input  logic                ras_push_if,
    input  logic                ras_pop_if,
    input  logic                B_type_ex,
    input  logic [5:0]          br_op_ex,
    input  logic [PC_WIDTH-1:0] rs1_ex,
    input  logic [PC_WIDTH-1:0] rs2_ex,
    input  logic [PC_WIDTH-1:0] pc_ex,
    input  logic [PC_WIDTH-1:0] imme_ex,
    input  logic                jalr_ex,
    input  logic [PC_WIDTH-1:0] jalr_target_ex,
    output logic                corrected_result,
    output logic                corrected_valid,
    output logic                PL_flush,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                B_type_branch_failed,
    output logic [5:0]          br_op_branch_failed,
    output logic [PC_WIDTH-1:0] pc_branch_failed,
    output logic                B_type_result_branch_failed,
    output logic                ras_rollback_pop,
    output logic                ras_rollback_push,
    output logic                stall_req
`ifdef BRANCH_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts,
    output logic [STAT_WIDTH-1:0] stat_jalr_miss
`endif
);

    typedef struct packed {
        logic                b_type;
        logic                pred;
        logic                jalr;
        logic [PC_WIDTH-1:0] jalr_pred;
        logic                push;
        logic                pop;
    } slot_t;

    typedef enum logic {IDLE, UNDO} state_t;

    state_t      state;
    slot_t       id_q;
    slot_t       ex_q;
    logic [3:0]  pend;
    logic        taken;
    logic        go;
    logic        mis_b;
    logic        mis_j;
    logic        mis;
    logic [3:0]  cand;
    logic [3:0]  cand_low;
    logic [3:0]  pend_low;
    logic [PC_WIDTH-1:0] target;
    logic        unused_slot;

    // Lowest set bit: the next undo action in queue order.
    function automatic logic [3:0] lowbit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    // Actual branch direction; malformed op encodings resolve not-taken.
    always_comb begin
        taken = 1'b0;
        if ($onehot(br_op_ex)) begin
            unique case (1'b1)
                br_op_ex[0]: taken = (rs1_ex == rs2_ex);
                br_op_ex[1]: taken = (rs1_ex != rs2_ex);
                br_op_ex[2]: taken = ($signed(rs1_ex) < $signed(rs2_ex));
                br_op_ex[3]: taken = ($signed(rs1_ex) >= $signed(rs2_ex));
                br_op_ex[4]: taken = (rs1_ex < rs2_ex);
                br_op_ex[5]: taken = (rs1_ex >= rs2_ex);
                default:     taken = 1'b0;
            endcase
        end
    end

    assign corrected_result = B_type_ex & taken;
    assign corrected_valid  = B_type_ex & ~PL_stall;

    assign go    = ~PL_stall & (state == IDLE);
    assign mis_b = go & B_type_ex & (taken != ex_q.pred);
    assign mis_j = go & ~B_type_ex & jalr_ex
                 & (jalr_target_ex != ex_q.jalr_pred);
    assign mis   = mis_b | mis_j;

    assign target = mis_b
        ? (taken ? pc_ex + imme_ex : pc_ex + PC_WIDTH'(4))
        : jalr_target_ex;

    // Even bits undo a push (emit pop), odd bits undo a pop (emit push).
    assign cand     = {id_q.pop, id_q.push, ras_pop_if, ras_push_if};
    assign cand_low = lowbit(cand);
    assign pend_low = lowbit(pend);

    assign unused_slot = ^{ex_q.b_type, ex_q.jalr, ex_q.push, ex_q.pop};

    // Shadow prediction pipe tracking the IF->ID->EX instruction flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (PL_flush) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (!PL_stall) begin
            ex_q <= id_q;
            id_q <= '{b_type:    B_type_if,
                      pred:      B_type_prediction_result,
                      jalr:      jalr_if,
                      jalr_pred: jalr_pc_prediction,
                      push:      ras_push_if,
                      pop:       ras_pop_if};
        end
    end

    // Flush pulse, redirect target and failed-branch bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            PL_flush                    <= 1'b0;
            redirect_pc                 <= '0;
            B_type_branch_failed        <= 1'b0;
            br_op_branch_failed         <= '0;
            pc_branch_failed            <= '0;
            B_type_result_branch_failed <= 1'b0;
        end else begin
            PL_flush <= mis;
            if (mis) begin
                redirect_pc                 <= target;
                B_type_branch_failed        <= B_type_ex;
                br_op_branch_failed         <= br_op_ex;
                pc_branch_failed            <= pc_ex;
                B_type_result_branch_failed <= ex_q.pred;
            end
        end
    end

    // RAS undo sequencer: one rollback action per cycle while stalling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pend              <= '0;
            stall_req         <= 1'b0;
            ras_rollback_pop  <= 1'b0;
            ras_rollback_push <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mis && cand != 4'd0) begin
                        state             <= UNDO;
                        pend              <= cand & ~cand_low;
                        stall_req         <= 1'b1;
                        ras_rollback_pop  <= |(cand_low & 4'b0101);
                        ras_rollback_push <= |(cand_low & 4'b1010);
                    end else begin
                        stall_req         <= 1'b0;
                        ras_rollback_pop  <= 1'b0;
                        ras_rollback_push <= 1'b0;
                    end
                end
                UNDO: begin
                    if (pend != 4'd0) begin
                        pend              <= pend & ~pend_low;
                        ras_rollback_pop  <= |(pend_low & 4'b0101);
                        ras_rollback_push <= |(pend_low & 4'b1010);
                    end else begin
                        state             <= IDLE;
                        stall_req         <= 1'b0;
                        ras_rollback_pop  <= 1'b0;
                        ras_rollback_push <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STAT_EN
    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            stat_jalr_miss   <= '0;
        end else begin
            if (corrected_valid && !(&stat_branches))
                stat_branches <= stat_branches + 1'b1;
            if (mis_b && !(&stat_mispredicts))
                stat_mispredicts <= stat_mispredicts + 1'b1;
            if (mis_j && !(&stat_jalr_miss))
                stat_jalr_miss <= stat_jalr_miss + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        PL_stall;
    logic        B_type_if;
    logic        B_type_prediction_result;
    logic        jalr_if;
    logic [31:0] jalr_pc_prediction;
    logic        ras_push_if;
    logic        ras_pop_if;
    logic        B_type_ex;
    logic [5:0]  br_op_ex;
    logic [31:0] rs1_ex;
    logic [31:0] rs2_ex;
    logic [31:0] pc_ex;
    logic [31:0] imme_ex;
    logic        jalr_ex;
    logic [31:0] jalr_target_ex;
    logic        corrected_result;
    logic        corrected_valid;
    logic        PL_flush;
    logic [31:0] redirect_pc;
    logic        B_type_branch_failed;
    logic [5:0]  br_op_branch_failed;
    logic [31:0] pc_branch_failed;
    logic        B_type_result_branch_failed;
    logic        ras_rollback_pop;
    logic        ras_rollback_push;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    branch_resolver #(.PC_WIDTH(32)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .PL_stall                    (PL_stall),
        .B_type_if                   (B_type_if),
        .B_type_prediction_result    (B_type_prediction_result),
        .jalr_if                     (jalr_if),
        .jalr_pc_prediction          (jalr_pc_prediction),
        .ras_push_if                 (ras_push_if),
        .ras_pop_if                  (ras_pop_if),
        .B_type_ex                   (B_type_ex),
        .br_op_ex                    (br_op_ex),
        .rs1_ex                      (rs1_ex),
        .rs2_ex                      (rs2_ex),
        .pc_ex                       (pc_ex),
        .imme_ex                     (imme_ex),
        .jalr_ex                     (jalr_ex),
        .jalr_target_ex              (jalr_target_ex),
        .corrected_result            (corrected_result),
        .corrected_valid             (corrected_valid),
        .PL_flush                    (PL_flush),
        .redirect_pc                 (redirect_pc),
        .B_type_branch_failed        (B_type_branch_failed),
        .br_op_branch_failed         (br_op_branch_failed),
        .pc_branch_failed            (pc_branch_failed),
        .B_type_result_branch_failed (B_type_result_branch_failed),
        .ras_rollback_pop            (ras_rollback_pop),
        .ras_rollback_push           (ras_rollback_push),
        .stall_req                   (stall_req)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] BEQ  = 6'b000001;
    localparam logic [5:0] BNE  = 6'b000010;
    localparam logic [5:0] BLT  = 6'b000100;
    localparam logic [5:0] BGE  = 6'b001000;
    localparam logic [5:0] BLTU = 6'b010000;
    localparam logic [5:0] BGEU = 6'b100000;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } vec_t;

    typedef struct packed {
        logic        b;
        logic        p;
        logic        j;
        logic [31:0] jp;
        logic        push;
        logic        pop;
    } slot_t;

    // Reference model state
    slot_t       m_id, m_ex;
    logic        m_flush;
    logic [31:0] m_redir, m_pcf;
    logic [5:0]  m_opf;
    logic        m_bf, m_resf;
    int          m_q[$];   // 1 = rollback_pop, 2 = rollback_push

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        PL_stall = 0; B_type_if = 0; B_type_prediction_result = 0;
        jalr_if = 0; jalr_pc_prediction = 0;
        ras_push_if = 0; ras_pop_if = 0;
        B_type_ex = 0; br_op_ex = 0; rs1_ex = 0; rs2_ex = 0;
        pc_ex = 0; imme_ex = 0; jalr_ex = 0; jalr_target_ex = 0;
    endtask

    task automatic do_reset;
        clr_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    function automatic logic ref_taken(input logic [5:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (op)
            BEQ:     return a == b;
            BNE:     return a != b;
            BLT:     return $signed(a) < $signed(b);
            BGE:     return !($signed(a) < $signed(b));
            BLTU:    return a < b;
            BGEU:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset;
        m_id = '0; m_ex = '0; m_flush = 0; m_redir = 0; m_pcf = 0;
        m_opf = 0; m_bf = 0; m_resf = 0;
        m_q.delete();
    endtask

    task automatic model_step;
        int    nq[$];
        logic  busy, tk, mb, mj;
        if (rst) begin
            model_reset();
            return;
        end
        nq = m_q;
        busy = (m_q.size() != 0);
        if (busy) void'(nq.pop_front());
        tk = ref_taken(br_op_ex, rs1_ex, rs2_ex);
        mb = !PL_stall && !busy && B_type_ex && (tk != m_ex.p);
        mj = !PL_stall && !busy && !B_type_ex && jalr_ex
           && (jalr_target_ex != m_ex.jp);
        if (mb || mj) begin
            if (mb) m_redir = tk ? pc_ex + imme_ex : pc_ex + 32'd4;
            else    m_redir = jalr_target_ex;
            m_bf = B_type_ex; m_opf = br_op_ex; m_pcf = pc_ex;
            m_resf = m_ex.p;
            nq.delete();
            if (ras_push_if) nq.push_back(1);
            if (ras_pop_if)  nq.push_back(2);
            if (m_id.push)   nq.push_back(1);
            if (m_id.pop)    nq.push_back(2);
        end
        if (m_flush) begin
            m_id = '0; m_ex = '0;
        end else if (!PL_stall) begin
            m_ex = m_id;
            m_id = '{b: B_type_if, p: B_type_prediction_result,
                     j: jalr_if, jp: jalr_pc_prediction,
                     push: ras_push_if, pop: ras_pop_if};
        end
        m_flush = mb || mj;
        m_q = nq;
    endtask

    function automatic logic [31:0] pick_op;
        int r = $urandom_range(0, 9);
        if (r < 8) return 32'(6'b1 << $urandom_range(0, 5));
        return 32'($urandom_range(0, 63));
    endfunction

    function automatic logic [31:0] pick_val;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd5;
            3: return 32'hFFFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_tgt;
        case ($urandom_range(0, 2))
            0: return 32'h400;
            1: return 32'h404;
            default: return 32'h800;
        endcase
    endfunction

    vec_t vt[$];
    int   npulse;

    initial begin
        rst = 0;
        clr_in();

        // Reset state
        do_reset();
        chk("rst_flush", 32'(PL_flush), 0);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_rbpop", 32'(ras_rollback_pop), 0);
        chk("rst_rbpush", 32'(ras_rollback_push), 0);
        chk("rst_redir", redirect_pc, 0);

        // Direction table, stalled so no flush side effects
        vt.push_back('{BEQ,  32'd5, 32'd5, 1'b1});
        vt.push_back('{BEQ,  32'd5, 32'd6, 1'b0});
        vt.push_back('{BNE,  32'd5, 32'd6, 1'b1});
        vt.push_back('{BNE,  32'd7, 32'd7, 1'b0});
        vt.push_back('{BLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1});
        vt.push_back('{BGE,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0});
        vt.push_back('{BGE,  32'd3, 32'd3, 1'b1});
        vt.push_back('{BLTU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0});
        vt.push_back('{BLTU, 32'd0, 32'hFFFF_FFFF, 1'b1});
        vt.push_back('{BGEU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
        vt.push_back('{BGEU, 32'd1, 32'd2, 1'b0});
        vt.push_back('{6'b000000, 32'd5, 32'd5, 1'b0});
        vt.push_back('{6'b000011, 32'd5, 32'd5, 1'b0});
        vt.push_back('{6'b100001, 32'd5, 32'd5, 1'b0});
        for (int i = 0; i < vt.size(); i++) begin
            PL_stall = 1; B_type_ex = 1;
            br_op_ex = vt[i].op; rs1_ex = vt[i].a; rs2_ex = vt[i].b;
            #1;
            chk($sformatf("tbl%0d_res", i), 32'(corrected_result),
                32'(vt[i].exp));
            chk($sformatf("tbl%0d_vld", i), 32'(corrected_valid), 0);
        end
        tick();
        chk("tbl_noflush", 32'(PL_flush), 0);

        // beq correctly predicted taken
        do_reset();
        B_type_if = 1; B_type_prediction_result = 1;
        tick(); clr_in(); tick();
        B_type_ex = 1; br_op_ex = BEQ; rs1_ex = 5; rs2_ex = 5;
        pc_ex = 32'h100; imme_ex = 32'h20;
        #1;
        chk("beq_res", 32'(corrected_result), 1);
        chk("beq_vld", 32'(corrected_valid), 1);
        tick();
        chk("beq_flush", 32'(PL_flush), 0);
        chk("beq_stall", 32'(stall_req), 0);

        // blt signed taken, predicted not-taken
        do_reset();
        B_type_if = 1; B_type_prediction_result = 0;
        tick(); clr_in(); tick();
        B_type_ex = 1; br_op_ex = BLT; rs1_ex = 32'hFFFF_FFFF;
        rs2_ex = 1; pc_ex = 32'h200; imme_ex = 32'h40;
        tick();
        chk("blt_flush", 32'(PL_flush), 1);
        chk("blt_redir", redirect_pc, 32'h240);
        chk("blt_res", 32'(B_type_result_branch_failed), 0);
        chk("blt_pc", pc_branch_failed, 32'h200);
        chk("blt_bt", 32'(B_type_branch_failed), 1);
        clr_in();
        tick();
        chk("blt_pulse", 32'(PL_flush), 0);

        // bltu unsigned not-taken, predicted taken
        do_reset();
        B_type_if = 1; B_type_prediction_result = 1;
        tick(); clr_in(); tick();
        B_type_ex = 1; br_op_ex = BLTU; rs1_ex = 32'hFFFF_FFFF;
        rs2_ex = 1; pc_ex = 32'h200; imme_ex = 32'h40;
        tick();
        chk("bltu_flush", 32'(PL_flush), 1);
        chk("bltu_redir", redirect_pc, 32'h204);
        chk("bltu_op", 32'(br_op_branch_failed), 32'b010000);
        chk("bltu_res", 32'(B_type_result_branch_failed), 1);

        // jalr target miss with RAS undo of IF pop then ID push
        do_reset();
        jalr_if = 1; jalr_pc_prediction = 32'h400;
        tick(); clr_in(); ras_push_if = 1;
        tick(); clr_in(); ras_pop_if = 1;
        jalr_ex = 1; jalr_target_ex = 32'h404;
        tick();
        chk("jalr_flush", 32'(PL_flush), 1);
        chk("jalr_redir", redirect_pc, 32'h404);
        chk("jalr_bt", 32'(B_type_branch_failed), 0);
        chk("jalr_n1_push", 32'(ras_rollback_push), 1);
        chk("jalr_n1_pop", 32'(ras_rollback_pop), 0);
        chk("jalr_n1_stall", 32'(stall_req), 1);
        clr_in();
        tick();
        chk("jalr_n2_flush", 32'(PL_flush), 0);
        chk("jalr_n2_pop", 32'(ras_rollback_pop), 1);
        chk("jalr_n2_push", 32'(ras_rollback_push), 0);
        chk("jalr_n2_stall", 32'(stall_req), 1);
        tick();
        chk("jalr_n3_stall", 32'(stall_req), 0);
        chk("jalr_n3_pop", 32'(ras_rollback_pop), 0);

        // Mispredict held under stall
        do_reset();
        B_type_if = 1; B_type_prediction_result = 0;
        tick(); clr_in(); tick();
        B_type_ex = 1; br_op_ex = BLT; rs1_ex = 32'hFFFF_FFFF;
        rs2_ex = 1; pc_ex = 32'h300; imme_ex = 32'h8;
        PL_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_flush", i), 32'(PL_flush), 0);
        end
        PL_stall = 0;
        tick();
        chk("stall_rel_flush", 32'(PL_flush), 1);
        chk("stall_rel_redir", redirect_pc, 32'h308);
        clr_in();
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            npulse += int'(PL_flush);
        end
        chk("stall_one_pulse", 32'(npulse), 0);

        // Reset in the second UNDO cycle aborts the sequence
        do_reset();
        B_type_if = 1; B_type_prediction_result = 0;
        tick(); clr_in(); ras_push_if = 1;
        tick(); clr_in();
        ras_push_if = 1; ras_pop_if = 1;
        B_type_ex = 1; br_op_ex = BLT; rs1_ex = 32'hFFFF_FFFF;
        rs2_ex = 1; pc_ex = 32'h500; imme_ex = 32'h10;
        tick();
        chk("abort_n1_pop", 32'(ras_rollback_pop), 1);
        chk("abort_n1_stall", 32'(stall_req), 1);
        clr_in();
        tick();
        chk("abort_n2_push", 32'(ras_rollback_push), 1);
        rst = 1;
        tick();
        rst = 0;
        chk("abort_flush", 32'(PL_flush), 0);
        chk("abort_stall", 32'(stall_req), 0);
        chk("abort_pop", 32'(ras_rollback_pop), 0);
        chk("abort_push", 32'(ras_rollback_push), 0);
        chk("abort_redir", redirect_pc, 0);
        chk("abort_pcf", pc_branch_failed, 0);
        chk("abort_bt", 32'(B_type_branch_failed), 0);
        npulse = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            npulse += int'(ras_rollback_pop) + int'(ras_rollback_push);
        end
        chk("abort_no_pulses", 32'(npulse), 0);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            PL_stall = ($urandom_range(0, 4) == 0);
            B_type_if = 1'($urandom);
            B_type_prediction_result = 1'($urandom);
            jalr_if = 1'($urandom);
            jalr_pc_prediction = pick_tgt();
            ras_push_if = ($urandom_range(0, 2) == 0);
            ras_pop_if = ($urandom_range(0, 2) == 0);
            B_type_ex = 1'($urandom);
            jalr_ex = 1'($urandom);
            br_op_ex = 6'(pick_op());
            rs1_ex = pick_val();
            rs2_ex = pick_val();
            pc_ex = $urandom;
            imme_ex = ($urandom_range(0, 1) == 1) ? $urandom
                    : 32'($urandom_range(0, 255));
            jalr_target_ex = pick_tgt();
            #1;
            chk("rnd_res", 32'(corrected_result),
                32'(B_type_ex & ref_taken(br_op_ex, rs1_ex, rs2_ex)));
            chk("rnd_vld", 32'(corrected_valid),
                32'(B_type_ex & !PL_stall));
            model_step();
            tick();
            chk("rnd_flush", 32'(PL_flush), 32'(m_flush));
            chk("rnd_redir", redirect_pc, m_redir);
            chk("rnd_bt", 32'(B_type_branch_failed), 32'(m_bf));
            chk("rnd_op", 32'(br_op_branch_failed), 32'(m_opf));
            chk("rnd_pc", pc_branch_failed, m_pcf);
            chk("rnd_bres", 32'(B_type_result_branch_failed), 32'(m_resf));
            chk("rnd_stall", 32'(stall_req), 32'(m_q.size() != 0));
            chk("rnd_rbpop", 32'(ras_rollback_pop),
                32'(m_q.size() != 0 && m_q[0] == 1));
            chk("rnd_rbpush", 32'(ras_rollback_push),
                32'(m_q.size() != 0 && m_q[0] == 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
EX-stage counterpart of the front-end branch predictor. It carries each IF-stage prediction (B-type direction, jalr target, RAS push/pop) through ID to EX. In EX it computes the actual outcome and detects mispredictions. On a misprediction it drives the pipeline flush, the redirect PC, the registered branch_failed bundle consumed by the predictor rollback logic, and a sequenced RAS undo for the squashed younger instructions.

Parameters:
PC_WIDTH, 32, width of PC, immediate, operands and targets
STAT_WIDTH, 32, width of statistics counters (used only with BRANCH_STAT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
PL_stall  in  1  global pipeline stall; shadow pipe holds when high
B_type_if  in  1  IF instruction is a conditional branch
B_type_prediction_result  in  1  predicted taken for the IF branch
jalr_if  in  1  IF instruction is jalr
jalr_pc_prediction  in  PC_WIDTH  predicted jalr target (from RAS)
ras_push_if  in  1  RAS push issued for IF instruction
ras_pop_if  in  1  RAS pop issued for IF instruction
B_type_ex  in  1  EX instruction is a conditional branch
br_op_ex  in  6  one-hot {bgeu,bltu,bge,blt,bne,beq}
rs1_ex, rs2_ex  in  PC_WIDTH  forwarded operands
pc_ex, imme_ex  in  PC_WIDTH  EX PC and B-immediate
jalr_ex  in  1  EX instruction is jalr
jalr_target_ex  in  PC_WIDTH  computed jalr target (LSB already cleared)
corrected_result  out  1  actual taken outcome of the EX branch (combinational)
corrected_valid  out  1  B_type_ex && !PL_stall
PL_flush  out  1  one-cycle flush pulse
redirect_pc  out  PC_WIDTH  fetch redirect target, valid with PL_flush
B_type_branch_failed  out  1  failing instruction was B-type, valid with PL_flush
br_op_branch_failed  out  6  one-hot op of the failing branch
pc_branch_failed  out  PC_WIDTH  PC of the failing instruction
B_type_result_branch_failed  out  1  predicted (wrong) direction of the failing branch
ras_rollback_pop  out  1  undo a squashed push
ras_rollback_push  out  1  undo a squashed pop
stall_req  out  1  high while RAS undo is pending

Behaviour:
- Reset: all outputs 0, shadow slots cleared, FSM = IDLE, undo queue empty.
- Shadow pipe: slots ID and EX each hold {B_type, pred, jalr, jalr_pred, push, pop}.
  - Advance IF→ID→EX when !PL_stall.
  - Cleared (both slots) in the cycle PL_flush is high.
- Actual direction:
  - beq: equal. bne: not equal.
  - blt/bge: signed compare. bltu/bgeu: unsigned compare.
  - An invalid one-hot br_op_ex (zero or multi-bit) gives not-taken.
- Mispredict in cycle N requires !PL_stall and FSM == IDLE, plus either:
  - B_type_ex && actual != shadow pred, or
  - jalr_ex && jalr_target_ex != shadow jalr_pred.
  - B_type takes priority if both B_type_ex and jalr_ex are asserted.
- Cycle N+1 (registered outputs):
  - PL_flush = 1.
  - redirect_pc = pc_ex+imme_ex if actually taken, pc_ex+4 if not taken, or jalr_target_ex for jalr. Addition wraps modulo 2^PC_WIDTH.
  - failed bundle = {B_type_ex, br_op_ex, pc_ex, shadow pred}.
- Undo queue, captured at cycle N:
  - Entry 0 = IF inputs {push, pop}; entry 1 = ID slot {push, pop}.
  - Entries with both flags 0 are dropped.
- FSM IDLE→UNDO at N+1 if the queue is non-empty; stall_req rises at N+1.
  - One action per cycle, entry 0 first.
  - Per entry: a push emits ras_rollback_pop; a pop emits ras_rollback_push. An entry with both flags emits rollback_pop, then rollback_push next cycle.
  - UNDO→IDLE after the last action; stall_req drops in that same cycle.
  - Maximum UNDO length is 4 cycles.
- While in UNDO, mispredict detection is masked and PL_flush stays 0.
- Reset mid-UNDO aborts the sequence immediately; no further rollback pulses.

Optional Feature:
BRANCH_STAT_EN: when defined, adds output ports stat_branches, stat_mispredicts, stat_jalr_miss (STAT_WIDTH each), reset to 0.
- stat_branches increments on corrected_valid.
- stat_mispredicts increments on a B-type mispredict.
- stat_jalr_miss increments on a jalr mispredict.
- All counters saturate at all-ones.
When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- beq, rs1=rs2=5, predicted taken, pc_ex=0x100, imme=0x20 → corrected_result=1, no PL_flush, stall_req=0.
- blt, rs1=0xFFFFFFFF, rs2=1, predicted not-taken, pc_ex=0x200, imme=0x40 → next cycle PL_flush=1, redirect_pc=0x240, B_type_result_branch_failed=0, pc_branch_failed=0x200.
- bltu with the same operands, predicted taken → actual not-taken, redirect_pc=pc_ex+4, br_op_branch_failed=6'b010000.
- jalr, jalr_pred=0x400, target=0x404, ID slot push=1, IF pop=1 → N+1 flush to 0x404; N+1 rollback_push, N+2 rollback_pop, stall_req high N+1..N+2.
- Mispredict held with PL_stall=1 for 3 cycles → no flush until stall drops, then exactly one PL_flush pulse.
- rst asserted during the second UNDO cycle → next cycle all outputs 0, FSM IDLE, no further rollback pulses.
